// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control unit:
// FSM states, instruction-field constants, ALU codes and control-select values.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_TEQ = 4'b1001;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_CMN = 4'b1011;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam int ALU_CODE_W = 3;
    localparam logic [ALU_CODE_W-1:0] ALU_ADD = 3'd0;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB = 3'd1;
    localparam logic [ALU_CODE_W-1:0] ALU_AND = 3'd2;
    localparam logic [ALU_CODE_W-1:0] ALU_ORR = 3'd3;
    localparam logic [ALU_CODE_W-1:0] ALU_EOR = 3'd4;
    localparam logic [ALU_CODE_W-1:0] ALU_MOV = 3'd5;

    localparam logic [1:0] FLAGS_NONE = 2'b00;
    localparam logic [1:0] FLAGS_NZ   = 2'b01;
    localparam logic [1:0] FLAGS_NZCV = 2'b11;

    localparam logic [1:0] SRCB_RM   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Compare-style commands update flags only; CondLogic suppresses their Rd write.
    function automatic logic is_compare(input logic [3:0] cmd);
        return (cmd == CMD_CMP) || (cmd == CMD_CMN) ||
               (cmd == CMD_TST) || (cmd == CMD_TEQ);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control-unit bundle: instruction fields and memory handshake in,
// write requests, datapath selects and ALU control out.
interface multicycle_ctrl_fsm_if #(
    parameter int ALU_CTRL_W = 3
);
    logic [1:0]            op;
    logic [5:0]            funct;
    logic [3:0]            rd;
    logic                  mem_ready;

    logic                  ir_write;
    logic                  next_pc;
    logic                  pcs;
    logic                  reg_w3;
    logic                  reg_w1;
    logic                  mem_w;
    logic                  no_write;
    logic [1:0]            flag_w;
    logic                  adr_src;
    logic                  alu_src_a;
    logic [1:0]            alu_src_b;
    logic [1:0]            result_src;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic [3:0]            state_o;

    modport master (
        input  op, funct, rd, mem_ready,
        output ir_write, next_pc, pcs, reg_w3, reg_w1, mem_w, no_write, flag_w,
               adr_src, alu_src_a, alu_src_b, result_src, alu_control, state_o
    );

    modport slave (
        output op, funct, rd, mem_ready,
        input  ir_write, next_pc, pcs, reg_w3, reg_w1, mem_w, no_write, flag_w,
               adr_src, alu_src_a, alu_src_b, result_src, alu_control, state_o
    );

endinterface

// File: rtl/multicycle_ctrl_fsm_alu_decoder.sv
// Data-processing command decode: ALU operation, flag-write class and
// compare-only indication. Idle (ADD, no flags) when alu_op is low.
module alu_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 3
) (
    input  logic [3:0]            cmd,
    input  logic                  s,
    input  logic                  alu_op,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [1:0]            flag_w,
    output logic                  no_write
);

    logic [ALU_CODE_W-1:0] op_code;
    logic                  arith;
    logic                  logical;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        op_code  = ALU_ADD;
        arith    = 1'b0;
        logical  = 1'b0;
        no_write = 1'b0;
        if (alu_op) begin
            case (cmd)
                CMD_ADD: begin op_code = ALU_ADD; arith   = 1'b1; end
                CMD_SUB: begin op_code = ALU_SUB; arith   = 1'b1; end
                CMD_CMP: begin op_code = ALU_SUB; arith   = 1'b1; end
                CMD_CMN: begin op_code = ALU_ADD; arith   = 1'b1; end
                CMD_AND: begin op_code = ALU_AND; logical = 1'b1; end
                CMD_TST: begin op_code = ALU_AND; logical = 1'b1; end
                CMD_ORR: begin op_code = ALU_ORR; logical = 1'b1; end
                CMD_EOR: begin op_code = ALU_EOR; logical = 1'b1; end
                CMD_TEQ: begin op_code = ALU_EOR; logical = 1'b1; end
                CMD_MOV: begin op_code = ALU_MOV; logical = 1'b1; end
                default: ;
            endcase
            no_write = is_compare(cmd);
        end
    end

    always_comb begin
        flag_w = FLAGS_NONE;
        if (s && arith)
            flag_w = FLAGS_NZCV;
        else if (s && logical)
            flag_w = FLAGS_NZ;
    end

    assign alu_control = ALU_CTRL_W'(op_code);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle ARM main controller: sequences fetch/decode/execute/writeback and
// issues the unconditional write requests that CondLogic qualifies.
module multicycle_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_ctrl_fsm_if.master bus
);

    state_t                state;
    state_t                state_next;

    logic                  p_bit;
    logic                  u_bit;
    logic                  w_bit;
    logic                  l_bit;
    logic                  rd_is_pc;

    logic                  alu_op;
    logic [ALU_CTRL_W-1:0] dec_alu_control;
    logic [1:0]            dec_flag_w;
    logic                  dec_no_write;

    logic                  ir_write_c;
    logic                  next_pc_c;
    logic                  pcs_c;
    logic                  reg_w3_c;
    logic                  reg_w1_c;
    logic                  mem_w_c;
    logic                  adr_src_c;
    logic                  alu_src_a_c;
    logic [1:0]            alu_src_b_c;
    logic [1:0]            result_src_c;
    logic [ALU_CTRL_W-1:0] alu_control_c;

    assign p_bit    = bus.funct[4];
    assign u_bit    = bus.funct[3];
    assign w_bit    = bus.funct[1];
    assign l_bit    = bus.funct[0];
    assign rd_is_pc = (bus.rd == 4'hF);

    assign alu_op = (state == EXECR) || (state == EXECI) || (state == ALUWB);

    alu_decoder #(
        .ALU_CTRL_W (ALU_CTRL_W)
    ) u_alu_decoder (
        .cmd         (bus.funct[4:1]),
        .s           (bus.funct[0]),
        .alu_op      (alu_op),
        .alu_control (dec_alu_control),
        .flag_w      (dec_flag_w),
        .no_write    (dec_no_write)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= FETCH;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:  state_next = bus.mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (bus.op)
                    OP_DP:   state_next = bus.funct[5] ? EXECI : EXECR;
                    OP_MEM:  state_next = MEMADR;
                    OP_BR:   state_next = BRANCH;
                    default: state_next = FETCH;
                endcase
            end
            MEMADR: state_next = l_bit ? MEMRD : MEMWR;
            MEMRD:  state_next = bus.mem_ready ? MEMWB : MEMRD;
            MEMWB:  state_next = FETCH;
            MEMWR:  state_next = bus.mem_ready ? FETCH : MEMWR;
            EXECR:  state_next = ALUWB;
            EXECI:  state_next = ALUWB;
            ALUWB:  state_next = FETCH;
            BRANCH: state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    // Selects default to the FETCH/DECODE PC+4 path; each state overrides what it needs.
    always_comb begin
        ir_write_c    = 1'b0;
        next_pc_c     = 1'b0;
        pcs_c         = 1'b0;
        reg_w3_c      = 1'b0;
        reg_w1_c      = 1'b0;
        mem_w_c       = 1'b0;
        adr_src_c     = 1'b0;
        alu_src_a_c   = 1'b1;
        alu_src_b_c   = SRCB_FOUR;
        result_src_c  = RES_ALU;
        alu_control_c = ALU_CTRL_W'(ALU_ADD);
        case (state)
            FETCH: begin
                ir_write_c = bus.mem_ready;
                next_pc_c  = bus.mem_ready;
            end
            DECODE: ;
            MEMADR: begin
                alu_src_a_c   = 1'b0;
                alu_src_b_c   = SRCB_IMM;
                alu_control_c = u_bit ? ALU_CTRL_W'(ALU_ADD) : ALU_CTRL_W'(ALU_SUB);
                reg_w1_c      = w_bit | ~p_bit;
            end
            MEMRD: adr_src_c = 1'b1;
            MEMWB: begin
                result_src_c = RES_RDATA;
                reg_w3_c     = 1'b1;
                pcs_c        = rd_is_pc;
            end
            MEMWR: begin
                adr_src_c = 1'b1;
                mem_w_c   = 1'b1;
            end
            EXECR: begin
                alu_src_a_c   = 1'b0;
                alu_src_b_c   = SRCB_RM;
                alu_control_c = dec_alu_control;
            end
            EXECI: begin
                alu_src_a_c   = 1'b0;
                alu_src_b_c   = SRCB_IMM;
                alu_control_c = dec_alu_control;
            end
            ALUWB: begin
                result_src_c  = RES_ALUOUT;
                reg_w3_c      = 1'b1;
                pcs_c         = rd_is_pc;
                alu_control_c = dec_alu_control;
            end
            BRANCH: begin
                alu_src_a_c = 1'b0;
                alu_src_b_c = SRCB_IMM;
                pcs_c       = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are gated by reset directly: FETCH with mem_ready high must not
    // fire ir_write/next_pc while reset is still asserted.
    assign bus.ir_write = reset & ir_write_c;
    assign bus.next_pc  = reset & next_pc_c;
    assign bus.pcs      = reset & pcs_c;
    assign bus.reg_w3   = reset & reg_w3_c;
    assign bus.reg_w1   = reset & reg_w1_c;
    assign bus.mem_w    = reset & mem_w_c;
    assign bus.flag_w   = (reset && state == ALUWB) ? dec_flag_w : FLAGS_NONE;
    assign bus.no_write = reset & dec_no_write & (state == ALUWB);

    assign bus.adr_src     = adr_src_c;
    assign bus.alu_src_a   = alu_src_a_c;
    assign bus.alu_src_b   = alu_src_b_c;
    assign bus.result_src  = result_src_c;
    assign bus.alu_control = alu_control_c;
    assign bus.state_o     = state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: table of data-processing
// instructions plus hand-built memory, branch, reset and undefined sequences.
module tb_multicycle_ctrl_fsm;
    import cpu_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm_if #(.ALU_CTRL_W(3)) bus ();

    multicycle_ctrl_fsm #(
        .ALU_CTRL_W (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0] state;
        logic       ir_write;
        logic       next_pc;
        logic       pcs;
        logic       reg_w3;
        logic       reg_w1;
        logic       mem_w;
        logic       no_write;
        logic [1:0] flag_w;
        logic       adr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [2:0] alu_control;
    } obs_t;

    typedef struct {
        string name;
        obs_t  exp;
    } sb_entry_t;

    typedef struct {
        string      name;
        logic [5:0] funct;
        logic [3:0] rd;
        state_t     exec_st;
        logic [1:0] src_b;
        logic [2:0] alu;
        logic [1:0] flag_w;
        logic       no_write;
        logic       pcs_wb;
    } dp_vec_t;

    sb_entry_t sb_q[$];
    dp_vec_t   vecs[12];
    int        checks = 0;
    int        errors = 0;

    task automatic check(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %06h (state %0d) expected %06h (state %0d)",
                     name, got, got.state, exp, exp.state);
        end
    endtask

    function automatic obs_t observe();
        obs_t o;
        o.state       = bus.state_o;
        o.ir_write    = bus.ir_write;
        o.next_pc     = bus.next_pc;
        o.pcs         = bus.pcs;
        o.reg_w3      = bus.reg_w3;
        o.reg_w1      = bus.reg_w1;
        o.mem_w       = bus.mem_w;
        o.no_write    = bus.no_write;
        o.flag_w      = bus.flag_w;
        o.adr_src     = bus.adr_src;
        o.alu_src_a   = bus.alu_src_a;
        o.alu_src_b   = bus.alu_src_b;
        o.result_src  = bus.result_src;
        o.alu_control = bus.alu_control;
        return o;
    endfunction

    // Quiet outputs of a state: no strobes, PC+4 selects, ALU add.
    function automatic obs_t at(input state_t s);
        obs_t o;
        o             = '0;
        o.state       = s;
        o.alu_src_a   = 1'b1;
        o.alu_src_b   = 2'b10;
        o.result_src  = 2'b10;
        o.alu_control = ALU_ADD;
        return o;
    endfunction

    function automatic obs_t fetch_exp(input logic mr);
        obs_t o;
        o          = at(FETCH);
        o.ir_write = mr;
        o.next_pc  = mr;
        return o;
    endfunction

    task automatic compare_head();
        sb_entry_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_underflow: got 0 entries required 1");
        end else begin
            e = sb_q.pop_front();
            check(e.name, observe(), e.exp);
        end
    endtask

    // One controller cycle: drive mem_ready at the falling edge, queue the
    // expectation, then sample mid-low-phase before the next rising edge.
    task automatic step(input logic mr, input obs_t exp, input string name);
        @(negedge clk);
        bus.mem_ready = mr;
        sb_q.push_back('{name, exp});
        #2;
        compare_head();
    endtask

    task automatic set_instr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd);
        bus.op    = op;
        bus.funct = funct;
        bus.rd    = rd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        obs_t e;

        vecs[0]  = '{"mov_pc",     6'b011010, 4'hF, EXECR, 2'b00, ALU_MOV, 2'b00, 1'b0, 1'b1};
        vecs[1]  = '{"adds_imm",   6'b101001, 4'h1, EXECI, 2'b01, ALU_ADD, 2'b11, 1'b0, 1'b0};
        vecs[2]  = '{"sub_reg",    6'b000100, 4'h3, EXECR, 2'b00, ALU_SUB, 2'b00, 1'b0, 1'b0};
        vecs[3]  = '{"cmp_reg",    6'b010101, 4'h0, EXECR, 2'b00, ALU_SUB, 2'b11, 1'b1, 1'b0};
        vecs[4]  = '{"cmn_imm",    6'b110111, 4'h0, EXECI, 2'b01, ALU_ADD, 2'b11, 1'b1, 1'b0};
        vecs[5]  = '{"ands_reg",   6'b000001, 4'h4, EXECR, 2'b00, ALU_AND, 2'b01, 1'b0, 1'b0};
        vecs[6]  = '{"orr_imm",    6'b111000, 4'h5, EXECI, 2'b01, ALU_ORR, 2'b00, 1'b0, 1'b0};
        vecs[7]  = '{"eors_reg",   6'b000011, 4'h6, EXECR, 2'b00, ALU_EOR, 2'b01, 1'b0, 1'b0};
        vecs[8]  = '{"tst_imm",    6'b110001, 4'h0, EXECI, 2'b01, ALU_AND, 2'b01, 1'b1, 1'b0};
        vecs[9]  = '{"teq_reg",    6'b010011, 4'h0, EXECR, 2'b00, ALU_EOR, 2'b01, 1'b1, 1'b0};
        vecs[10] = '{"rsbs_unsup", 6'b000111, 4'h7, EXECR, 2'b00, ALU_ADD, 2'b00, 1'b0, 1'b0};
        vecs[11] = '{"movs_imm",   6'b111011, 4'h3, EXECI, 2'b01, ALU_MOV, 2'b01, 1'b0, 1'b0};

        reset = 1'b0;
        set_instr(OP_BR, 6'b000000, 4'h0);
        bus.mem_ready = 1'b1;

        // Reset held with mem_ready high: FETCH selects, no strobes.
        #3;
        sb_q.push_back('{"reset_hold", at(FETCH)});
        compare_head();
        #4 reset = 1'b1;

        // Branch, with two wait cycles in FETCH first.
        step(1'b0, fetch_exp(1'b0), "b_fetch_wait0");
        step(1'b0, fetch_exp(1'b0), "b_fetch_wait1");
        step(1'b1, fetch_exp(1'b1), "b_fetch");
        step(1'b1, at(DECODE), "b_decode");
        e = at(BRANCH); e.alu_src_a = 1'b0; e.alu_src_b = 2'b01; e.pcs = 1'b1;
        step(1'b1, e, "b_branch");

        // Data-processing table; first entry is MOV pc,r0 right after the branch.
        for (int i = 0; i < 12; i++) begin
            set_instr(OP_DP, vecs[i].funct, vecs[i].rd);
            step(1'b1, fetch_exp(1'b1), {vecs[i].name, "_fetch"});
            step(1'b1, at(DECODE), {vecs[i].name, "_decode"});
            e = at(vecs[i].exec_st);
            e.alu_src_a   = 1'b0;
            e.alu_src_b   = vecs[i].src_b;
            e.alu_control = vecs[i].alu;
            step(1'b1, e, {vecs[i].name, "_exec"});
            e = at(ALUWB);
            e.result_src  = 2'b00;
            e.reg_w3      = 1'b1;
            e.pcs         = vecs[i].pcs_wb;
            e.flag_w      = vecs[i].flag_w;
            e.no_write    = vecs[i].no_write;
            e.alu_control = vecs[i].alu;
            step(1'b1, e, {vecs[i].name, "_aluwb"});
        end

        // LDR pre-index, no writeback, memory stalls three cycles in MEMRD.
        set_instr(OP_MEM, 6'b011001, 4'h2);
        step(1'b1, fetch_exp(1'b1), "ldr_fetch");
        step(1'b1, at(DECODE), "ldr_decode");
        e = at(MEMADR); e.alu_src_a = 1'b0; e.alu_src_b = 2'b01;
        step(1'b0, e, "ldr_memadr");
        e = at(MEMRD); e.adr_src = 1'b1;
        step(1'b0, e, "ldr_memrd_wait0");
        step(1'b0, e, "ldr_memrd_wait1");
        step(1'b0, e, "ldr_memrd_wait2");
        step(1'b1, e, "ldr_memrd_done");
        e = at(MEMWB); e.result_src = 2'b01; e.reg_w3 = 1'b1;
        step(1'b0, e, "ldr_memwb");
        step(1'b0, fetch_exp(1'b0), "ldr_back_to_fetch");

        // LDR pre-index with writeback into pc.
        set_instr(OP_MEM, 6'b011011, 4'hF);
        step(1'b1, fetch_exp(1'b1), "ldrw_fetch");
        step(1'b1, at(DECODE), "ldrw_decode");
        e = at(MEMADR); e.alu_src_a = 1'b0; e.alu_src_b = 2'b01; e.reg_w1 = 1'b1;
        step(1'b1, e, "ldrw_memadr");
        e = at(MEMRD); e.adr_src = 1'b1;
        step(1'b1, e, "ldrw_memrd");
        e = at(MEMWB); e.result_src = 2'b01; e.reg_w3 = 1'b1; e.pcs = 1'b1;
        step(1'b1, e, "ldrw_memwb_pc");

        // STR post-index, down: base writeback, SUB, mem_w held until ready.
        set_instr(OP_MEM, 6'b000000, 4'h4);
        step(1'b1, fetch_exp(1'b1), "str_fetch");
        step(1'b1, at(DECODE), "str_decode");
        e = at(MEMADR); e.alu_src_a = 1'b0; e.alu_src_b = 2'b01; e.reg_w1 = 1'b1;
        e.alu_control = ALU_SUB;
        step(1'b0, e, "str_memadr");
        e = at(MEMWR); e.adr_src = 1'b1; e.mem_w = 1'b1;
        step(1'b0, e, "str_memwr_wait0");
        step(1'b0, e, "str_memwr_wait1");
        step(1'b1, e, "str_memwr_done");
        step(1'b0, fetch_exp(1'b0), "str_back_to_fetch");

        // Reset asserted in the middle of a MEMWR cycle.
        set_instr(OP_MEM, 6'b011000, 4'h5);
        step(1'b1, fetch_exp(1'b1), "strr_fetch");
        step(1'b1, at(DECODE), "strr_decode");
        e = at(MEMADR); e.alu_src_a = 1'b0; e.alu_src_b = 2'b01;
        step(1'b0, e, "strr_memadr");
        e = at(MEMWR); e.adr_src = 1'b1; e.mem_w = 1'b1;
        step(1'b0, e, "strr_memwr");
        #1 reset = 1'b0;
        #1;
        sb_q.push_back('{"strr_reset_async", fetch_exp(1'b0)});
        compare_head();
        @(posedge clk);
        #2 reset = 1'b1;
        step(1'b0, fetch_exp(1'b0), "strr_after_release");

        // Undefined op=11 goes DECODE -> FETCH without any strobe.
        set_instr(2'b11, 6'b111111, 4'hF);
        step(1'b1, fetch_exp(1'b1), "undef_fetch");
        step(1'b1, at(DECODE), "undef_decode");
        step(1'b0, fetch_exp(1'b0), "undef_back_to_fetch");

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
